// File: rtl/rr_arb4_if.sv
// Request/grant bundle between requesting units and the rr_arb4 round-robin arbiter.
interface rr_arb4_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_idx;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_idx
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_idx
    );
endinterface

// File: rtl/rr_arb4.sv
// Registered 4-requester round-robin arbiter with grant locking and direct handoff.
// Optional owner hold limit enabled by defining RR_HOLD_LIMIT_EN.
module rr_arb4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic      i_clock,
    input  logic      i_reset,
    rr_arb4_if.slave  arb
);

    typedef enum logic {StIdle, StGrant} state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb4: MAX_HOLD must be in 1..255");
    end

    state_t     r_state;
    logic [3:0] r_gnt;
    logic       r_valid;
    logic [1:0] r_idx;
    logic [1:0] r_ptr;

    state_t     w_state_d;
    logic [3:0] w_gnt_d;
    logic [1:0] w_idx_d;
    logic [1:0] w_ptr_d;
    logic       w_new;
    logic       w_force;
    logic [3:0] w_others;

    // Highest priority is ptr itself, then descending with wrap.
    function automatic logic [1:0] f_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        f_pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr - 2'(i);
            if (req[idx]) f_pick = idx;
        end
    endfunction

    assign w_others = arb.req & ~(4'b0001 << r_idx);

`ifdef RR_HOLD_LIMIT_EN
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
    logic [7:0] r_hold;

    assign w_force = (r_hold >= HoldLast) && (|w_others);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hold <= 8'd0;
        end else if (w_new) begin
            r_hold <= 8'd0;
        end else if (r_state == StGrant && w_state_d == StGrant && r_hold != 8'hFF) begin
            r_hold <= r_hold + 8'd1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_ptr_d   = r_ptr;
        w_new     = 1'b0;
        w_gnt_d   = 4'b0000;
        unique case (r_state)
            StIdle: begin
                if (arb.en && (|arb.req)) begin
                    w_new     = 1'b1;
                    w_idx_d   = f_pick(arb.req, r_ptr);
                    w_state_d = StGrant;
                end
            end
            StGrant: begin
                if (!arb.en) begin
                    w_state_d = StIdle;
                end else if (arb.req[r_idx] && !w_force) begin
                    w_state_d = StGrant;
                end else if (|w_others) begin
                    // Owner is excluded so it can never win its own handoff.
                    w_new   = 1'b1;
                    w_idx_d = f_pick(w_others, r_ptr);
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_new) w_ptr_d = w_idx_d - 2'd1;
        if (w_state_d == StGrant) w_gnt_d = 4'b0001 << w_idx_d;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
            r_idx   <= 2'd0;
            r_ptr   <= 2'd3;
        end else begin
            r_state <= w_state_d;
            r_gnt   <= w_gnt_d;
            r_valid <= (w_state_d == StGrant);
            r_idx   <= w_idx_d;
            r_ptr   <= w_ptr_d;
        end
    end

    assign arb.gnt       = r_gnt;
    assign arb.gnt_valid = r_valid;
    assign arb.gnt_idx   = r_idx;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: rule-level reference model plus directed literal checks.
module tb_rr_arb4;

    localparam int MH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rr_arb4_if u_if ();

    rr_arb4 #(
        .MAX_HOLD (MH)
    ) u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .arb     (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RR_HOLD_LIMIT_EN
    localparam bit HoldLimit = 1'b1;
`else
    localparam bit HoldLimit = 1'b0;
`endif

    // Reference model: owner/pointer tracked as plain integers.
    bit m_started;
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_hold;

    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (ptr - k + 4) % 4;
            if (r[c]) return c;
        end
        return ptr;
    endfunction

    initial begin
        m_started = 1'b0;
        m_valid   = 1'b0;
        m_idx     = 0;
        m_ptr     = 3;
        m_hold    = 0;
    end

    always @(posedge clk) begin
        logic [3:0] others;
        bit         force_off;
        m_started = 1'b1;
        if (rst) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = 3;
            m_hold  = 0;
        end else if (!m_valid) begin
            if (u_if.en && u_if.req != 4'b0000) begin
                m_idx   = pick(u_if.req, m_ptr);
                m_ptr   = (m_idx + 3) % 4;
                m_valid = 1'b1;
                m_hold  = 0;
            end
        end else if (!u_if.en) begin
            m_valid = 1'b0;
        end else begin
            others    = u_if.req;
            others[m_idx] = 1'b0;
            force_off = HoldLimit && (m_hold >= MH - 1) && (others != 4'b0000);
            if (u_if.req[m_idx] && !force_off) begin
                if (m_hold < 255) m_hold = m_hold + 1;
            end else if (others != 4'b0000) begin
                m_idx  = pick(others, m_ptr);
                m_ptr  = (m_idx + 3) % 4;
                m_hold = 0;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_gnt;
        if (m_started) begin
            exp_gnt = m_valid ? (4'b0001 << m_idx) : 4'b0000;
            checks++;
            if (u_if.gnt !== exp_gnt || u_if.gnt_valid !== m_valid ||
                u_if.gnt_idx !== 2'(m_idx)) begin
                failures++;
                $display("FAIL model t=%0t gnt=%b valid=%b idx=%0d required gnt=%b valid=%b idx=%0d",
                         $time, u_if.gnt, u_if.gnt_valid, u_if.gnt_idx, exp_gnt, m_valid, m_idx);
            end
            checks++;
            if ($countones(u_if.gnt) > 1 || u_if.gnt_valid !== (|u_if.gnt)) begin
                failures++;
                $display("FAIL onehot t=%0t gnt=%b valid=%b required one-hot/zero with valid=|gnt",
                         $time, u_if.gnt, u_if.gnt_valid);
            end
        end
    end

    task automatic step(input logic e, input logic [3:0] r);
        u_if.en  = e;
        u_if.req = r;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] idx);
        checks++;
        if (u_if.gnt !== g || u_if.gnt_valid !== (|g) || u_if.gnt_idx !== idx) begin
            failures++;
            $display("FAIL %s gnt=%b valid=%b idx=%0d required gnt=%b valid=%b idx=%0d",
                     name, u_if.gnt, u_if.gnt_valid, u_if.gnt_idx, g, |g, idx);
        end
    endtask

    initial begin
        logic [3:0] g;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        u_if.en  = 1'b1;
        u_if.req = 4'b1111;
        @(negedge clk);
        expect_out("reset", 4'b0000, 2'd0);

        rst = 1'b0;
        step(1'b1, 4'b1111); expect_out("first_grant", 4'b1000, 2'd3);
        step(1'b1, 4'b1111); expect_out("held", 4'b1000, 2'd3);
        step(1'b1, 4'b0111); expect_out("handoff_2", 4'b0100, 2'd2);
        step(1'b1, 4'b0011); expect_out("handoff_1", 4'b0010, 2'd1);
        step(1'b1, 4'b1001); expect_out("handoff_0", 4'b0001, 2'd0);
        step(1'b1, 4'b1000); expect_out("handoff_3", 4'b1000, 2'd3);

        // Fairness rotation: owner drops, all others keep requesting.
        step(1'b1, 4'b0111); expect_out("fair_2", 4'b0100, 2'd2);
        step(1'b1, 4'b1011); expect_out("fair_1", 4'b0010, 2'd1);
        step(1'b1, 4'b1101); expect_out("fair_0", 4'b0001, 2'd0);
        step(1'b1, 4'b1110); expect_out("fair_3", 4'b1000, 2'd3);

        step(1'b1, 4'b0100); expect_out("pre_en_off", 4'b0100, 2'd2);
        step(1'b0, 4'b0100); expect_out("en_off", 4'b0000, 2'd2);
        step(1'b1, 4'b0110); expect_out("ptr_1", 4'b0010, 2'd1);
        step(1'b1, 4'b0011); expect_out("hold_1", 4'b0010, 2'd1);

        rst = 1'b1;
        step(1'b1, 4'b0001); expect_out("reset_mid", 4'b0000, 2'd0);
        rst = 1'b0;
        step(1'b1, 4'b0001); expect_out("after_reset", 4'b0001, 2'd0);
        step(1'b1, 4'b1100); expect_out("after_reset_3", 4'b1000, 2'd3);

        rst = 1'b1;
        step(1'b1, 4'b0000); expect_out("reset_ptr", 4'b0000, 2'd0);
        rst = 1'b0;
        step(1'b1, 4'b1001); expect_out("ptr_restart", 4'b1000, 2'd3);
        step(1'b1, 4'b0001); expect_out("to_0", 4'b0001, 2'd0);

        step(1'b0, 4'b0000); expect_out("idle_a", 4'b0000, 2'd0);
        step(1'b0, 4'b1111); expect_out("idle_en0", 4'b0000, 2'd0);
        step(1'b1, 4'b0000); expect_out("idle_noreq", 4'b0000, 2'd0);

        rst = 1'b1;
        step(1'b1, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'b0101);
            if (HoldLimit) g = (i < 4 || i >= 8) ? 4'b0100 : 4'b0001;
            else           g = 4'b0100;
            expect_out($sformatf("hold_seq_%0d", i), g, (g == 4'b0100) ? 2'd2 : 2'd0);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 4'b0100);
        expect_out("hold_alone", 4'b0100, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb4.md
Name: rr_arb4

Overview:
- Registered 4-requester round-robin arbiter that shares one resource among requesters.
- Sequential successor to the combinational 4-bit priority selector (highest index wins, gated by en). Keeps that selector's one-hot gnt convention.
- Adds a rotating priority pointer, grant locking while the owner keeps requesting, and direct handoff between owners.
- Sits between requesting units and a shared port (e.g. a bus or functional unit).

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant while others wait. Used only with RR_HOLD_LIMIT_EN. Legal range 1..255.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  arbitration enable; 0 forces the grant off
- req  input  4  request vector; bit i = requester i
- gnt  output  4  registered one-hot grant, or 0000
- gnt_valid  output  1  registered; equals |gnt
- gnt_idx  output  2  registered index of granted requester; holds last owner when gnt_valid=0

Behaviour:
- Reset (sync, reset=1 at an edge): gnt=0000, gnt_valid=0, gnt_idx=00, ptr=3, state=IDLE, hold counter=0. reset overrides every other input.
- Priority order: start at ptr, then descend with wrap: ptr, ptr-1, ..., ptr-3 (mod 4). First requesting index wins.
  - At reset, order is 3,2,1,0, identical to the combinational selector.
- On every new grant to index k: ptr <= (k-1) mod 4, so k becomes lowest priority. Examples: k=0 gives ptr=3; k=3 gives ptr=2.
- States: IDLE (no owner) and GRANT (owner = gnt_idx).
- IDLE:
  - en=1 and req!=0: next cycle gnt=onehot(winner), gnt_valid=1, gnt_idx=winner, go to GRANT. Latency is exactly 1 cycle from request to grant.
  - Otherwise stay IDLE with gnt=0000.
- GRANT:
  - en=0: next cycle gnt=0000, go to IDLE, ptr unchanged.
  - req[gnt_idx]=1 and en=1: hold the grant unchanged; ptr unchanged.
  - req[gnt_idx]=0 and other bits of req set: direct handoff. Next cycle grant the winner from the current ptr order, no bubble cycle, ptr updated.
  - req[gnt_idx]=0 and req=0000: next cycle gnt=0000, go to IDLE.
- The old owner is never re-granted in the same handoff: ptr already ranks it last, and its req bit is 0.
- gnt is always one-hot or zero; never more than one bit set.
- Inputs are sampled only at the clock edge; no combinational path from req/en to gnt.
- Reset asserted in GRANT: grant drops on that edge and ptr returns to 3.

Optional Feature:
- Macro: RR_HOLD_LIMIT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each cycle the owner is held.
  - When the counter reaches MAX_HOLD-1 and any other req bit is set, the next cycle forces a handoff as if req[gnt_idx] were 0, with ptr updated.
  - If no other requester is waiting, the owner keeps the grant and the counter saturates.
- Not defined: no counter logic; the owner holds indefinitely while req[gnt_idx]=1 and en=1.

Test Plan:
- Reset then en=1, req=1111 -> gnt=0000 in the reset cycle, gnt=1000 / gnt_idx=3 one cycle later. Grant held while req=1111 (macro off).
- From the above, req=0111 -> next cycle gnt=0100, no zero cycle. Then req=0011 -> gnt=0010. Then req=1001 -> gnt=0001, then req=1000 -> gnt=1000.
- Fairness: each owner drops its req for one cycle after every grant, all others held high -> grants rotate 1000, 0100, 0010, 0001, 1000. No index is granted twice before all others are granted.
- en=0 while gnt=0100 -> next cycle gnt=0000, gnt_valid=0, gnt_idx stays 2. en=1 with req=0110 -> gnt=0010 (ptr=1).
- reset asserted mid-grant with req=0001 held -> gnt=0000 on that edge. After reset release, gnt=0001 a cycle later and ptr restarts at 3, so a later req=1001 handoff picks 3.
- RR_HOLD_LIMIT_EN, MAX_HOLD=4, req=0101 held constant -> gnt=0100 for 4 cycles, 0001 for 4, 0100 for 4. With req=0100 alone -> gnt=0100 held indefinitely.
